// File: rtl/packet_unload.sv
// packet_unload: snapshots a packed byte buffer on load and streams its valid bytes oldest-first over valid/ready.
// Ports: clk, rst_n (async active-low); a_in/count_in/load snapshot request; byte_out/byte_valid/byte_ready
// byte stream; tfin one-cycle done pulse; busy in SEND or DONE; remaining bytes not yet accepted.
module packet_unload #(
  parameter int NBYTES = 16,
  parameter int CW = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [8*NBYTES-1:0] a_in,
  input  logic [CW-1:0]       count_in,
  input  logic                load,
  output logic [7:0]          byte_out,
  output logic                byte_valid,
  input  logic                byte_ready,
  output logic                tfin,
  output logic                busy,
  output logic [CW:0]         remaining
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int IW = $clog2(8*NBYTES);
  logic [1:0] state;
  logic [8*NBYTES-1:0] snap;
  logic [IW-1:0] ld_idx, nx_idx;
  // With r bytes left, the current byte sits at bit 8*(r-1), so the stored
  // count is never needed: the oldest of N is at 8*(N-1), the next at 8*(r-2).
  always_comb begin
    ld_idx = IW'(8 * (int'(count_in) - 1));
    nx_idx = IW'(8 * (int'(remaining) - 2));
  end
  assign tfin = state == DONE;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      snap       <= '0;
      remaining  <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
    end else if (state == IDLE) begin
      if (load && count_in != '0) begin
        snap       <= a_in;
        remaining  <= {1'b0, count_in};
        byte_out   <= a_in[ld_idx +: 8];
        byte_valid <= 1'b1;
        state      <= SEND;
      end
    end else if (state == SEND) begin
      if (byte_ready) begin
        remaining <= remaining - 1'b1;
        if (remaining > 1) begin
          byte_out <= snap[nx_idx +: 8];
        end else begin
          byte_out   <= '0;
          byte_valid <= 1'b0;
          state      <= DONE;
        end
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_packet_unload.sv
// tb_packet_unload: randomized and directed checks of packet_unload against a byte-queue reference model.
module tb_packet_unload;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] a_in = '0;
  logic [3:0]   count_in = '0;
  logic         load = 1'b0;
  logic [7:0]   byte_out;
  logic         byte_valid;
  logic         byte_ready = 1'b0;
  logic         tfin;
  logic         busy;
  logic [4:0]   remaining;
  int n_checks = 0;
  int n_fail = 0;

  packet_unload #(.NBYTES(16), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .count_in(count_in), .load(load),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .tfin(tfin), .busy(busy), .remaining(remaining)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, byte_valid, 0);
    check({tag, "_tfin"}, tfin, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_remaining"}, remaining, 0);
  endtask

  // mode: 0 ready always, 1 ready pattern 1,0,0, 2 random ready.
  // disturb: hold load high with new data throughout SEND and DONE.
  // abort_after: assert reset once that many bytes were accepted (-1 never).
  task automatic send_packet(input logic [127:0] a, input int n, input int mode,
                             input bit disturb, input int abort_after);
    logic [7:0] q[$];
    logic [127:0] t;
    int sent, cyc;
    bit rdy;
    t = a;
    for (int i = 0; i < n; i++) begin
      q.push_front(t[7:0]);
      t = t >> 8;
    end
    a_in = a;
    count_in = 4'(n);
    load = 1'b1;
    byte_ready = 1'b0;
    step();
    load = disturb;
    sent = 0;
    cyc = 0;
    while (q.size() > 0 && cyc < 200) begin
      check("valid", byte_valid, 1);
      check("byte", byte_out, q[0]);
      check("remaining", remaining, q.size());
      check("tfin_send", tfin, 0);
      check("busy_send", busy, 1);
      if (sent == abort_after) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", byte_valid, 0);
        check("rst_remaining", remaining, 0);
        check("rst_busy", busy, 0);
        check("rst_tfin", tfin, 0);
        check("rst_byte", byte_out, 0);
        load = 1'b0;
        step();
        check("rst_hold_tfin", tfin, 0);
        step();
        check("rst_hold_valid", byte_valid, 0);
        rst_n = 1'b1;
        step();
        check_idle("post_rst");
        return;
      end
      rdy = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      byte_ready = rdy;
      a_in = {$urandom, $urandom, $urandom, $urandom};
      count_in = disturb ? 4'd5 : 4'($urandom);
      step();
      cyc++;
      if (rdy) begin
        void'(q.pop_front());
        sent++;
      end
    end
    check("timeout_left", q.size(), 0);
    check("done_valid", byte_valid, 0);
    check("done_byte", byte_out, 0);
    check("done_tfin", tfin, 1);
    check("done_busy", busy, 1);
    check("done_remaining", remaining, 0);
    byte_ready = 1'b0;
    step();
    load = 1'b0;
    check("after_tfin", tfin, 0);
    check("after_busy", busy, 0);
    check("after_valid", byte_valid, 0);
  endtask

  initial begin
    logic [127:0] seq;
    #23;
    check("reset_byte", byte_out, 0);
    check_idle("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check_idle("idle");
    end
    seq = '0;
    for (int v = 1; v <= 15; v++) seq = (seq << 8) | 128'(v);
    send_packet(seq, 15, 0, 1'b0, -1);
    send_packet(seq, 15, 1, 1'b0, -1);
    send_packet({{13{8'hFF}}, 24'hAABBCC}, 3, 0, 1'b0, -1);
    a_in = {$urandom, $urandom, $urandom, $urandom};
    count_in = 4'd0;
    load = 1'b1;
    step();
    load = 1'b0;
    check_idle("zero_load");
    step();
    check_idle("zero_load2");
    send_packet({$urandom, $urandom, $urandom, $urandom}, 9, 2, 1'b1, -1);
    send_packet(seq, 15, 0, 1'b0, 4);
    send_packet(seq, 15, 0, 1'b0, -1);
    for (int p = 0; p < 20; p++)
      send_packet({$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(1, 15)), 2, 1'(p % 2), -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
